// File: rtl/shift_seq.sv
// Multi-cycle universal shift register: hold/load/clear execute in one cycle,
// shift and rotate ops step one bit per clock under a start/busy/done handshake.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_srsi,
    input  logic             i_slsi,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_sro,
    output logic             o_slo,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SLL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic [0:0]       r_state;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_done;
    logic [WIDTH-1:0] w_step;
    logic             w_isShift;

    // Serial inputs are taken live on every step edge, never latched at start.
    always_comb begin
        w_step = r_dout;
        case (r_op)
            OP_SRL:  w_step = {i_srsi, r_dout[WIDTH-1:1]};
            OP_SLL:  w_step = {r_dout[WIDTH-2:0], i_slsi};
            OP_ROR:  w_step = {r_dout[0], r_dout[WIDTH-1:1]};
            OP_ROL:  w_step = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
            OP_ASR:  w_step = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
            default: w_step = r_dout;
        endcase
    end

    assign w_isShift = (i_op >= OP_SRL) && (i_op <= OP_ASR);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_op    <= 3'b000;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    if (w_isShift && (i_amt != '0)) begin
                        r_op    <= i_op;
                        r_cnt   <= i_amt;
                        r_state <= S_RUN;
                    end else begin
                        r_done <= 1'b1;
                        if (i_op == OP_LOAD) begin
                            r_dout <= i_din;
                        end else if (i_op == OP_CLEAR) begin
                            r_dout <= '0;
                        end
                    end
                end
            end else begin
                // Starts arriving here are dropped; the running op owns the register.
                r_dout <= w_step;
                r_cnt  <= r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_dout = r_dout;
    assign o_sro  = r_dout[0];
    assign o_slo  = r_dout[WIDTH-1];
    assign o_busy = (r_state == S_RUN);
    assign o_done = r_done;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed walk through the documented scenarios with literal
// expectations, then randomized commands checked every cycle against a step model.
module tb_shift_seq;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          clrn;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic          srsi;
    logic          slsi;
    logic [W-1:0]  dout;
    logic          sro;
    logic          slo;
    logic          busy;
    logic          done;

    int nCompared = 0;
    int nMismatch = 0;
    bit chkEn = 0;

    logic [W-1:0] mDout = '0;
    logic [2:0]   mOp = 3'b000;
    int           mRem = 0;
    logic         mDone = 1'b0;

    shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .clrn(clrn), .i_start(start), .i_op(op), .i_amt(amt),
        .i_din(din), .i_srsi(srsi), .i_slsi(slsi), .o_dout(dout),
        .o_sro(sro), .o_slo(slo), .o_busy(busy), .o_done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] stepOp(input logic [2:0] o, input logic [W-1:0] d,
                                            input logic si_r, input logic si_l);
        logic [W-1:0] r;
        case (o)
            3'b010: begin r = d >> 1; r[W-1] = si_r; end
            3'b011: r = (d << 1) | W'(si_l);
            3'b100: r = (d >> 1) | (d << (W-1));
            3'b101: r = (d << 1) | (d >> (W-1));
            3'b110: r = W'($signed(d) >>> 1);
            default: r = d;
        endcase
        return r;
    endfunction

    // Reference: remaining-step count plus expected register value.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mDout = '0; mRem = 0; mDone = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mRem > 0) begin
                mDout = stepOp(mOp, mDout, srsi, slsi);
                mRem  = mRem - 1;
                if (mRem == 0) mDone = 1'b1;
            end else if (start) begin
                if (op >= 3'd2 && op <= 3'd6 && amt != 0) begin
                    mOp = op; mRem = int'(amt);
                end else begin
                    mDone = 1'b1;
                    if (op == 3'd1) mDout = din;
                    if (op == 3'd7) mDout = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (chkEn) begin
            nCompared++;
            if ({dout, sro, slo, busy, done} !== {mDout, mDout[0], mDout[W-1], (mRem > 0), mDone}) begin
                nMismatch++;
                $display("[TB] FAIL model t=%0t: got dout=%h sro=%b slo=%b busy=%b done=%b, expected dout=%h sro=%b slo=%b busy=%b done=%b",
                         $time, dout, sro, slo, busy, done, mDout, mDout[0], mDout[W-1], (mRem > 0), mDone);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] eDout,
                               input logic eBusy, input logic eDone);
        nCompared++;
        if (dout !== eDout || busy !== eBusy || done !== eDone) begin
            nMismatch++;
            $display("[TB] FAIL %s: got dout=%h busy=%b done=%b, expected dout=%h busy=%b done=%b",
                     name, dout, busy, done, eDout, eBusy, eDone);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        start = 1'b1; op = o; amt = a; din = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        clrn = 0; start = 0; op = 0; amt = 0; din = 0; srsi = 0; slsi = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        clrn = 1; chkEn = 1;

        applyStimulus(3'b001, 4'd0, 8'hFF);
        checkOutput("loadFF", 8'hFF, 1'b0, 1'b1);
        applyStimulus(3'b010, 4'd5, 8'h00);
        checkOutput("srlAccept", 8'hFF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("srlTwoSteps", 8'h3F, 1'b1, 1'b0);
        clrn = 0;
        #1;
        checkOutput("resetMidRun", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        clrn = 1;
        applyStimulus(3'b000, 4'd0, 8'h00);
        checkOutput("holdAfterReset", 8'h00, 1'b0, 1'b1);

        applyStimulus(3'b001, 4'd0, 8'hA5);
        checkOutput("loadA5", 8'hA5, 1'b0, 1'b1);
        srsi = 1;
        applyStimulus(3'b010, 4'd3, 8'h00);
        checkOutput("srl3Accept", 8'hA5, 1'b1, 1'b0);
        @(negedge clk); checkOutput("srl3Step1", 8'hD2, 1'b1, 1'b0);
        @(negedge clk); checkOutput("srl3Step2", 8'hE9, 1'b1, 1'b0);
        @(negedge clk); checkOutput("srl3Done", 8'hF4, 1'b0, 1'b1);
        srsi = 0;

        applyStimulus(3'b001, 4'd0, 8'h81);
        applyStimulus(3'b101, 4'd9, 8'h00);
        repeat (8) @(negedge clk);
        checkOutput("rol9Step8", 8'h81, 1'b1, 1'b0);
        @(negedge clk); checkOutput("rol9Done", 8'h03, 1'b0, 1'b1);

        applyStimulus(3'b001, 4'd0, 8'h81);
        slsi = 0;
        applyStimulus(3'b011, 4'd1, 8'h00);
        @(negedge clk); checkOutput("sll1Done", 8'h02, 1'b0, 1'b1);

        applyStimulus(3'b001, 4'd0, 8'h90);
        applyStimulus(3'b110, 4'd2, 8'h00);
        start = 1; op = 3'b111;
        @(negedge clk); checkOutput("asrStep1", 8'hC8, 1'b1, 1'b0);
        start = 0;
        @(negedge clk); checkOutput("asrIgnoredClear", 8'hE4, 1'b0, 1'b1);

        applyStimulus(3'b001, 4'd0, 8'h5A);
        applyStimulus(3'b010, 4'd0, 8'h00);
        checkOutput("srlZero", 8'h5A, 1'b0, 1'b1);
        start = 1; op = 3'b001; din = 8'h3C;
        @(negedge clk);
        start = 0;
        checkOutput("backToBackLoad", 8'h3C, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clrn  = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            amt   = AW'($urandom_range(0, 15));
            din   = W'($urandom);
            srsi  = 1'($urandom);
            slsi  = 1'($urandom);
        end
        @(negedge clk);
        clrn = 1; start = 0;
        repeat (20) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
